// File: rtl/chaos_shift_keygen.sv
// chaos_shift_keygen: logistic-map generator streaming the M then N shift-key arrays
module chaos_shift_keygen #(
    parameter int unsigned WARMUP = 64,
    parameter int unsigned ROWS   = 256,
    parameter int unsigned COLS   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic [17:0] r_param,
    output logic        busy,
    output logic        done,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        key_sel,
    output logic [7:0]  key_idx,
    output logic [7:0]  key_data
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WARM   = 3'd1;
    localparam logic [2:0] CALC_A = 3'd2;
    localparam logic [2:0] CALC_B = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;
    localparam logic [8:0] LAST   = 9'(ROWS + COLS - 1);

    logic [2:0]  r_state;
    logic [15:0] r_x;
    logic [17:0] r_r;
    logic [15:0] r_p;
    logic [8:0]  r_cnt;
    logic [31:0] r_wcnt;
    logic [15:0] w_p;
    logic [17:0] w_q;
    logic [15:0] w_xn;

    // p = x*(1-x) in Q0.16; 1-x is the bitwise complement
    assign w_p  = 16'(({16'd0, r_x} * {16'd0, ~r_x}) >> 16);
    // q = r*p in Q2.16, saturated to the Q0.16 range and kept off the zero fixed point
    assign w_q  = 18'(({16'd0, r_r} * {18'd0, r_p}) >> 16);
    assign w_xn = (w_q > 18'h0FFFF) ? 16'hFFFF : ((w_q == 18'd0) ? 16'h0001 : w_q[15:0]);

    assign key_valid = (r_state == OUT);
    assign key_data  = r_x[15:8];
    assign key_sel   = r_cnt[8];
    assign key_idx   = r_cnt[7:0];
    assign busy      = (r_state != IDLE) && (r_state != FIN);
    assign done      = (r_state == FIN);

    // Sequencer: latch inputs, warm up the map, then emit one word per iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_r     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_x     <= (seed == 16'd0) ? 16'h0001 : seed;
                    r_r     <= r_param;
                    r_cnt   <= '0;
                    r_wcnt  <= '0;
                    r_state <= CALC_A;
                end
                WARM, CALC_A: begin
                    r_p     <= w_p;
                    r_state <= CALC_B;
                end
                CALC_B: begin
                    r_x <= w_xn;
                    if (r_wcnt < WARMUP) begin
                        r_wcnt  <= r_wcnt + 32'd1;
                        r_state <= WARM;
                    end else begin
                        r_state <= OUT;
                    end
                end
                OUT: if (key_ready) begin
                    r_cnt   <= r_cnt + 9'd1;
                    r_state <= (r_cnt == LAST) ? FIN : CALC_A;
                end
                FIN: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chaos_shift_keygen.sv
// tb_chaos_shift_keygen: directed/random runs checked against an arithmetic logistic-map model
module tb_chaos_shift_keygen;
    logic        clk = 0;
    logic        rst = 1;
    logic        start0 = 0;
    logic        start1 = 0;
    logic [15:0] seed = '0;
    logic [17:0] r_param = '0;
    logic        ready = 1;
    logic        b0, dn0, v0, s0, b1, dn1, v1, s1;
    logic [7:0]  i0, k0, i1, k1;
    logic        use1 = 0;
    logic        busy, done, kv, ks;
    logic [7:0]  ki, kd;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  g0, g1;

    always #5 clk = ~clk;

    chaos_shift_keygen #(.WARMUP(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .seed(seed), .r_param(r_param),
        .busy(b0), .done(dn0), .key_valid(v0), .key_ready(ready),
        .key_sel(s0), .key_idx(i0), .key_data(k0)
    );

    chaos_shift_keygen #(.WARMUP(64)) u1 (
        .clk(clk), .rst(rst), .start(start1), .seed(seed), .r_param(r_param),
        .busy(b1), .done(dn1), .key_valid(v1), .key_ready(ready),
        .key_sel(s1), .key_idx(i1), .key_data(k1)
    );

    assign busy = use1 ? b1 : b0;
    assign done = use1 ? dn1 : dn0;
    assign kv   = use1 ? v1 : v0;
    assign ks   = use1 ? s1 : s0;
    assign ki   = use1 ? i1 : i0;
    assign kd   = use1 ? k1 : k0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] x, input logic [17:0] r);
        longint p, q;
        p = (longint'(x) * (65535 - longint'(x))) / 65536;
        q = (longint'(r) * p) / 65536;
        if (q > 65535) q = 65535;
        if (q == 0) q = 1;
        return 16'(q);
    endfunction

    task automatic run(input logic [15:0] sd, input logic [17:0] rp, input bit w1,
                       input int stall_w, input int dist_cyc, input int rst_w,
                       output logic [7:0] dat0, output logic [7:0] dat1);
        logic [15:0] expx [512];
        logic [15:0] x;
        int warm, wi, cyc, stall, first;
        warm = w1 ? 64 : 0;
        x = (sd == 16'd0) ? 16'h0001 : sd;
        repeat (warm + 1) x = step(x, rp);
        for (int k = 0; k < 512; k++) begin
            expx[k] = x;
            x = step(x, rp);
        end
        dat0 = 'x;
        dat1 = 'x;
        @(negedge clk);
        use1 = w1;
        seed = sd;
        r_param = rp;
        ready = 1;
        if (w1) start1 = 1; else start0 = 1;
        wi = 0; cyc = 0; stall = 0; first = -1;
        while (wi < 512 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start0 = 0;
            start1 = 0;
            if (cyc == dist_cyc) begin
                seed = ~sd;
                r_param = rp ^ 18'h155;
                if (w1) start1 = 1; else start0 = 1;
            end
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            if (kv) begin
                if (first < 0) begin
                    first = cyc;
                    chk("latency", first, 2 * warm + 3);
                end
                if (wi == 0) dat0 = kd;
                if (wi == 1) dat1 = kd;
                chk("data", 32'(kd), 32'(expx[wi][15:8]));
                chk("idx", 32'(ki), 32'(wi[7:0]));
                chk("sel", 32'(ks), 32'(wi[8]));
                if (wi == rst_w) begin
                    rst = 1;
                    #1;
                    chk("rst_valid", 32'(kv), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_idx", 32'(ki), 32'd0);
                    @(negedge clk);
                    rst = 0;
                    return;
                end
                if (wi == stall_w && stall < 10) begin
                    ready = 0;
                    stall++;
                end else begin
                    ready = 1;
                    wi++;
                end
            end
        end
        chk("word_count", wi, 512);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_fin", 32'(busy), 32'd0);
        chk("valid_fin", 32'(kv), 32'd0);
        @(negedge clk);
        chk("done_once", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'({v0, v1}), 32'd0);
        chk("reset_busy", 32'({b0, b1}), 32'd0);
        chk("reset_done", 32'({dn0, dn1}), 32'd0);
        chk("reset_keys", 32'({s0, i0, k0}), 32'd0);
        rst = 0;
        run(16'h8000, 18'h3FFFF, 0, -1, -1, -1, g0, g1);
        chk("golden_w0", 32'(g0), 32'hFF);
        chk("golden_w1", 32'(g1), 32'h00);
        run(16'h0000, 18'($urandom_range(18'h3FFFF, 18'h2E000)), 0, -1, -1, -1, g0, g1);
        chk("zero_w0", 32'(g0), 32'h00);
        run(16'($urandom), 18'($urandom_range(18'h3FFFF, 18'h2E000)), 0, 5, -1, -1, g0, g1);
        run(16'($urandom), 18'($urandom_range(18'h3FFFF, 18'h2E000)), 0, -1, 50, -1, g0, g1);
        run(16'($urandom), 18'($urandom_range(18'h3FFFF, 18'h2E000)), 0, -1, -1, 100, g0, g1);
        run(16'($urandom), 18'($urandom_range(18'h3FFFF, 18'h2E000)), 0, 300, -1, -1, g0, g1);
        run(16'($urandom), 18'($urandom_range(18'h3FFFF, 18'h2E000)), 1, 7, -1, -1, g0, g1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
